trap_unit: RTL and testbench

TRAP_UNIT -- requirements
Module: trap_unit

---
 rtl/trap_unit.sv | 133 +++++++++++++
 tb/tb_trap_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_unit.sv
// Machine-mode trap unit: ecall entry, mret return and the trap CSRs; redirect one cycle after accept.
// No backpressure: o_busy stalls issue while a redirect is in flight, and inputs are ignored meanwhile.
module trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ecall,
    input  logic        i_mret,
    input  logic [31:0] i_pc,
    input  logic        i_csrWrite,
    input  logic [11:0] i_csrAddr,
    input  logic [31:0] i_csrWdata,
    output logic [31:0] o_csrRdata,
    output logic        o_redirect,
    output logic [31:0] o_redirectPc,
    output logic        o_busy
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        RETURN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        mie;
    logic        mpie;
    logic [31:0] mscratch;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;

    logic accept_ecall;
    logic accept_mret;
    logic csr_we;

    // ecall wins over mret; a CSR write never lands in the same cycle as a trap event
    assign accept_ecall = (state == IDLE) && i_ecall;
    assign accept_mret  = (state == IDLE) && i_mret && !i_ecall;
    assign csr_we       = (state == IDLE) && i_csrWrite && !i_ecall && !i_mret;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        o_redirect   = 1'b0;
        o_redirectPc = 32'h0000_0000;
        o_busy       = 1'b0;
        case (state)
            IDLE: begin
                if (accept_ecall) begin
                    state_nxt = ENTER;
                end else if (accept_mret) begin
                    state_nxt = RETURN;
                end
            end
            ENTER: begin
                o_redirect   = 1'b1;
                o_redirectPc = {mtvec[31:2], 2'b00};
                o_busy       = 1'b1;
                state_nxt    = IDLE;
            end
            RETURN: begin
                o_redirect   = 1'b1;
                o_redirectPc = mepc;
                o_busy       = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mscratch <= 32'h0000_0000;
            mtvec    <= RESET_MTVEC;
            mepc     <= 32'h0000_0000;
            mcause   <= 32'h0000_0000;
        end else if (accept_ecall) begin
            mepc   <= i_pc & ~32'd3;
            mcause <= 32'd11;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (accept_mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (csr_we) begin
            case (i_csrAddr)
                ADDR_MSTATUS: begin
                    mie  <= i_csrWdata[3];
                    mpie <= i_csrWdata[7];
                end
                ADDR_MTVEC:    mtvec    <= i_csrWdata;
                ADDR_MSCRATCH: mscratch <= i_csrWdata;
                ADDR_MEPC:     mepc     <= i_csrWdata & ~32'd3;
                ADDR_MCAUSE:   mcause   <= i_csrWdata;
                default: ;
            endcase
        end
    end

    // MPP is hardwired to machine mode
    always_comb begin
        o_csrRdata = 32'h0000_0000;
        case (i_csrAddr)
            ADDR_MSTATUS:  o_csrRdata = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
            ADDR_MTVEC:    o_csrRdata = mtvec;
            ADDR_MSCRATCH: o_csrRdata = mscratch;
            ADDR_MEPC:     o_csrRdata = mepc;
            ADDR_MCAUSE:   o_csrRdata = mcause;
            default:       o_csrRdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: expectations queued at drive time, popped and compared at sample time.
module tb_trap_unit;

    localparam logic [31:0] RST_VEC = 32'h0000_0080;

    logic        i_clk;
    logic        i_rst;
    logic        i_ecall;
    logic        i_mret;
    logic [31:0] i_pc;
    logic        i_csrWrite;
    logic [11:0] i_csrAddr;
    logic [31:0] i_csrWdata;
    logic [31:0] o_csrRdata;
    logic        o_redirect;
    logic [31:0] o_redirectPc;
    logic        o_busy;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    trap_unit #(.RESET_MTVEC(RST_VEC)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ecall     (i_ecall),
        .i_mret      (i_mret),
        .i_pc        (i_pc),
        .i_csrWrite  (i_csrWrite),
        .i_csrAddr   (i_csrAddr),
        .i_csrWdata  (i_csrWdata),
        .o_csrRdata  (o_csrRdata),
        .o_redirect  (o_redirect),
        .o_redirectPc(o_redirectPc),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic push(input string tag, input logic [31:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_next(input logic [31:0] obs);
        sb_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_empty observed=%h required=<queued value>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        i_csrAddr = addr;
        push(tag, exp);
        #1;
        check_next(o_csrRdata);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        @(negedge i_clk);
        i_csrWrite = 1'b1;
        i_csrAddr  = addr;
        i_csrWdata = data;
        @(negedge i_clk);
        i_csrWrite = 1'b0;
    endtask

    task automatic clear_inputs();
        i_ecall    = 1'b0;
        i_mret     = 1'b0;
        i_csrWrite = 1'b0;
        i_pc       = 32'h0;
        i_csrWdata = 32'h0;
    endtask

    initial begin
        clear_inputs();
        i_csrAddr = 12'h000;
        i_rst     = 1'b1;
        #3;
        push("rst_redirect", 32'd0);
        push("rst_busy", 32'd0);
        push("rst_pc", 32'd0);
        check_next({31'd0, o_redirect});
        check_next({31'd0, o_busy});
        check_next(o_redirectPc);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        rd(12'h300, 32'h0000_1800, "rst_mstatus");
        rd(12'h305, RST_VEC,       "rst_mtvec");
        rd(12'h341, 32'h0,         "rst_mepc");
        rd(12'h342, 32'h0,         "rst_mcause");
        rd(12'h340, 32'h0,         "rst_mscratch");
        rd(12'h123, 32'h0,         "unimpl_read");

        wr(12'h305, 32'h0000_0103);
        wr(12'h300, 32'h0000_0008);
        wr(12'h7C0, 32'hFFFF_FFFF);
        rd(12'h305, 32'h0000_0103, "mtvec_wr");
        rd(12'h300, 32'h0000_1808, "mstatus_mie_set");
        rd(12'h7C0, 32'h0,         "unimpl_write");

        // ecall; wrong-path ecall and mscratch write presented during ENTER
        @(negedge i_clk);
        i_ecall = 1'b1;
        i_pc    = 32'h0000_0208;
        push("ecall_redirect", 32'd1);
        push("ecall_pc", 32'h0000_0100);
        push("ecall_busy", 32'd1);
        @(negedge i_clk);
        i_pc       = 32'h0000_0F00;
        i_csrWrite = 1'b1;
        i_csrAddr  = 12'h340;
        i_csrWdata = 32'hDEAD_BEEF;
        #1;
        check_next({31'd0, o_redirect});
        check_next(o_redirectPc);
        check_next({31'd0, o_busy});
        @(negedge i_clk);
        clear_inputs();
        push("enter_done_redirect", 32'd0);
        push("enter_done_busy", 32'd0);
        #1;
        check_next({31'd0, o_redirect});
        check_next({31'd0, o_busy});
        rd(12'h340, 32'h0,         "enter_write_ignored");
        rd(12'h341, 32'h0000_0208, "ecall_mepc");
        rd(12'h342, 32'd11,        "ecall_mcause");
        rd(12'h300, 32'h0000_1880, "ecall_mstatus");

        @(negedge i_clk);
        i_mret = 1'b1;
        push("mret_redirect", 32'd1);
        push("mret_pc", 32'h0000_0208);
        @(negedge i_clk);
        i_mret = 1'b0;
        #1;
        check_next({31'd0, o_redirect});
        check_next(o_redirectPc);
        @(negedge i_clk);
        rd(12'h300, 32'h0000_1888, "mret_mstatus");
        rd(12'h341, 32'h0000_0208, "mret_mepc_kept");

        // simultaneous ecall + mret + mscratch write
        wr(12'h340, 32'h0000_0055);
        @(negedge i_clk);
        i_ecall    = 1'b1;
        i_mret     = 1'b1;
        i_pc       = 32'h0000_0300;
        i_csrWrite = 1'b1;
        i_csrAddr  = 12'h340;
        i_csrWdata = 32'h0000_00AA;
        push("simul_redirect", 32'd1);
        push("simul_pc_enter", 32'h0000_0100);
        @(negedge i_clk);
        clear_inputs();
        #1;
        check_next({31'd0, o_redirect});
        check_next(o_redirectPc);
        @(negedge i_clk);
        rd(12'h340, 32'h0000_0055, "simul_mscratch");
        rd(12'h341, 32'h0000_0300, "simul_mepc");
        rd(12'h300, 32'h0000_1880, "simul_mstatus");

        // back-to-back ecall: held through ENTER, accepted again in the next IDLE
        @(negedge i_clk);
        i_csrAddr = 12'h341;
        i_ecall   = 1'b1;
        i_pc      = 32'h0000_040C;
        @(negedge i_clk);
        i_pc = 32'h0000_0600;
        push("b2b_first_redirect", 32'd1);
        push("b2b_first_mepc", 32'h0000_040C);
        #1;
        check_next({31'd0, o_redirect});
        check_next(o_csrRdata);
        @(negedge i_clk);
        i_pc = 32'h0000_0512;
        push("b2b_idle_redirect", 32'd0);
        push("b2b_enter_ignored", 32'h0000_040C);
        #1;
        check_next({31'd0, o_redirect});
        check_next(o_csrRdata);
        @(negedge i_clk);
        clear_inputs();
        push("b2b_second_redirect", 32'd1);
        push("b2b_second_mepc", 32'h0000_0510);
        #1;
        check_next({31'd0, o_redirect});
        check_next(o_csrRdata);
        @(negedge i_clk);

        wr(12'h341, 32'h0000_0407);
        rd(12'h341, 32'h0000_0404, "mepc_align");

        // reset asserted mid-RETURN
        wr(12'h300, 32'h0000_0088);
        wr(12'h340, 32'h0000_1234);
        wr(12'h342, 32'h0000_0007);
        @(negedge i_clk);
        i_mret = 1'b1;
        push("ret_redirect", 32'd1);
        push("ret_pc", 32'h0000_0404);
        @(negedge i_clk);
        i_mret = 1'b0;
        #1;
        check_next({31'd0, o_redirect});
        check_next(o_redirectPc);
        #1;
        i_rst = 1'b1;
        push("arst_redirect", 32'd0);
        push("arst_busy", 32'd0);
        push("arst_pc", 32'd0);
        #1;
        check_next({31'd0, o_redirect});
        check_next({31'd0, o_busy});
        check_next(o_redirectPc);
        rd(12'h300, 32'h0000_1800, "arst_mstatus");
        rd(12'h305, RST_VEC,       "arst_mtvec");
        rd(12'h341, 32'h0,         "arst_mepc");
        rd(12'h342, 32'h0,         "arst_mcause");
        rd(12'h340, 32'h0,         "arst_mscratch");

        // first edge after reset release accepts an ecall
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_ecall = 1'b1;
        i_pc    = 32'h0000_0044;
        push("post_rst_redirect", 32'd1);
        push("post_rst_pc", RST_VEC);
        @(negedge i_clk);
        clear_inputs();
        #1;
        check_next({31'd0, o_redirect});
        check_next(o_redirectPc);
        @(negedge i_clk);
        rd(12'h341, 32'h0000_0044, "post_rst_mepc");
        rd(12'h342, 32'd11,        "post_rst_mcause");

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover observed=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
